ip_log2frac: RTL and testbench
==============================

Name: ip_log2frac

Overview:
- Multi-cycle fractional-part Log2 stage, directly downstream of the integer Log2 stage.
- Takes the original operand plus its integer log2 (floor(log2(x)) from the upstream stage's 1T update pulse).
- Normalizes the operand to a mantissa in [1,2), then computes FRWID fractional bits by repeated squaring, one bit per cycle.
- Output is the combined fixed-point log2 {integer, fraction} for downstream exposure/gain logic.

Parameters:
- IDWID, 16, input operand width.
- ODWID, log2(IDWID) (ceiling, same function as upstream), integer-part width.
- FRWID, 8, fractional-bit count = number of squaring iterations.
- MWID, 16, mantissa precision in 1.(MWID-1) format; must be >= IDWID.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_cal_str  input  1  calculation start, 1T pulse; driven from upstream o_val_upd
- i_val  input  IDWID  operand, sampled when i_cal_str=1
- i_int  input  ODWID  floor(log2(i_val)) from upstream, sampled when i_cal_str=1
- o_frac  output  FRWID  fractional log2 bits, MSB = 2^-1
- o_log2  output  ODWID+FRWID  {int_q, o_frac}
- o_val_vld  output  1  result valid (level)
- o_val_upd  output  1  1T result update pulse
- o_busy  output  1  iteration in progress

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. All registers clear on reset: o_frac=0, int_q=0, o_log2=0, o_val_vld=0, o_val_upd=0, o_busy=0, mantissa=0, iteration counter=0, state=IDLE.
- States: IDLE, SQR.
  - IDLE: on i_cal_str -> SQR.
  - SQR: counter increments each cycle; after the FRWID-th iteration -> IDLE.
  - i_cal_str in SQR restarts the calculation: reload and counter=0; the previous result is discarded with no o_val_upd for it.
- On the i_cal_str cycle (registered at that edge):
  - int_q <= min(i_int, IDWID-1).
  - mantissa <= (i_val << (IDWID-1-int_q)), placed in the top IDWID bits of MWID; lower bits 0.
  - o_frac <= 0; o_val_vld <= 0; o_busy <= 1.
- Each SQR cycle:
  - p = m*m (2*MWID bits, value in [1,4)).
  - If p[2*MWID-1]=1: next frac bit = 1, m <= p[2*MWID-1 -: MWID].
  - Else: next frac bit = 0, m <= p[2*MWID-2 -: MWID].
  - Truncation only, no rounding. Bits shift into o_frac from the LSB; after FRWID cycles the first bit sits in the MSB.
- Latency:
  - i_cal_str sampled at edge E0.
  - Iterations at edges E1..EFRWID.
  - At edge EFRWID: o_val_upd=1 for exactly 1 cycle, o_val_vld=1, o_busy=0.
  - Result is available FRWID cycles after start.
- o_val_vld stays 1 until the next i_cal_str clears it on the same edge the start is sampled. If i_cal_str coincides with the final iteration edge, start wins: no upd pulse, vld stays 0.
- o_frac and o_log2 are stable whenever o_val_vld=1. During SQR they hold partial bits and must be ignored.
- i_val=0: mantissa=0, every iteration yields 0; result o_log2=0 with normal vld/upd timing (log2(0) is defined as 0, consistent with upstream).
- i_int inconsistent with i_val (mantissa MSB not set): the algorithm runs unchanged. The result is deterministic per the rules above; there is no error flag and no hang.
- i_cal_str in IDLE with no prior result behaves identically to the first start.

Test Plan:
- IDWID=16, FRWID=8: i_val=0x0001, i_int=0 -> after 8 cycles upd pulse 1T, o_frac=0x00, o_log2=0x000, vld=1.
- i_val=0x0003, i_int=1 -> o_frac=0x95, o_log2={1,0x95}; upd exactly 8 cycles after start; busy high for cycles 1..8 (busy rises on the start edge, falls on the final iteration edge).
- i_val=0xFFFF, i_int=15 -> o_frac=0xFF. Then i_val=0x8000, i_int=15 -> o_frac=0x00, o_log2={15,0x00}. vld drops on the second start and rises again.
- i_val=0x000A, i_int=3 -> o_frac=0x52. Re-assert i_cal_str with i_val=0x0003, i_int=1 at iteration 4 -> no upd for the first; upd 8 cycles after the restart with o_frac=0x95.
- i_val=0, i_int=0 -> o_log2=0, vld=1. Assert rst_n=0 mid-SQR -> all outputs 0 immediately; no upd after release until a new start.
- Chain with the upstream integer Log2 stage (its o_val_upd -> i_cal_str, its o_val -> i_int), random i_val. Check o_log2 against floor(256*log2(i_val))/256 within 1 LSB (truncation may drop 1 LSB); the integer field must match exactly.

Source files
------------

// File: rtl/ip_log2frac.sv
// ip_log2frac: fractional-part log2 stage, downstream of the integer log2 stage.
// It normalizes the operand to a mantissa in [1,2) using the supplied integer
// log2. It then produces FRWID fraction bits by repeated squaring, one bit per
// cycle. The combined fixed-point result is {integer, fraction}.
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   i_cal_str  1T start pulse (upstream o_val_upd); samples i_val and i_int
//   i_val      operand
//   i_int      floor(log2(i_val)) from the upstream stage
//   o_frac     fraction bits, MSB weight 2^-1
//   o_log2     {integer, fraction}
//   o_val_vld  result valid (level)
//   o_val_upd  1T pulse when a new result lands
//   o_busy     iteration in progress
module ip_log2frac #(
    parameter int unsigned IDWID = 16,
    parameter int unsigned ODWID = $clog2(IDWID),
    parameter int unsigned FRWID = 8,
    parameter int unsigned MWID  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cal_str,
    input  logic [IDWID-1:0]       i_val,
    input  logic [ODWID-1:0]       i_int,
    output logic [FRWID-1:0]       o_frac,
    output logic [ODWID+FRWID-1:0] o_log2,
    output logic                   o_val_vld,
    output logic                   o_val_upd,
    output logic                   o_busy
);

    localparam int unsigned CWID  = $clog2(FRWID + 1);
    localparam int unsigned PWID  = 2 * MWID;
    localparam int unsigned INT_MAX = IDWID - 1;

    typedef enum logic {
        IDLE = 1'b0,
        SQR  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CWID-1:0]     cnt_q,   cnt_d;
    logic [MWID-1:0]     m_q,     m_d;
    logic [FRWID-1:0]    frac_q,  frac_d;
    logic [ODWID-1:0]    int_q,   int_d;
    logic                vld_q,   vld_d;
    logic                upd_q,   upd_d;
    logic                busy_q,  busy_d;

    logic [ODWID-1:0]    int_clamp;
    logic [ODWID-1:0]    shamt;
    logic [IDWID-1:0]    mant_ld;
    logic [PWID-1:0]     sq;
    logic [MWID:0]       sq_top;
    logic                sq_bit;
    logic [MWID-1:0]     sq_norm;

    // Load path: clamp the integer part and left-justify the operand.
    always_comb begin
        int_clamp = (i_int > ODWID'(INT_MAX)) ? ODWID'(INT_MAX) : i_int;
        shamt     = ODWID'(INT_MAX) - int_clamp;
        mant_ld   = i_val << shamt;
    end

    // Squaring step: the product is in [0,4). Its top bit is the next fraction
    // bit and selects the renormalizing slice, with truncation only.
    always_comb begin
        sq      = PWID'(m_q) * PWID'(m_q);
        sq_top  = (MWID+1)'(sq >> (MWID - 1));
        sq_bit  = sq_top[MWID];
        sq_norm = sq_bit ? sq_top[MWID:1] : sq_top[MWID-1:0];
    end

    // Next-state and register inputs; a start takes priority in any state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        frac_d  = frac_q;
        int_d   = int_q;
        vld_d   = vld_q;
        upd_d   = 1'b0;
        busy_d  = busy_q;

        if (i_cal_str) begin
            state_d = SQR;
            cnt_d   = '0;
            int_d   = int_clamp;
            m_d     = MWID'(mant_ld) << (MWID - IDWID);
            frac_d  = '0;
            vld_d   = 1'b0;
            busy_d  = 1'b1;
        end else begin
            case (state_q)
                SQR: begin
                    m_d    = sq_norm;
                    frac_d = (frac_q << 1) | FRWID'(sq_bit);
                    cnt_d  = cnt_q + CWID'(1);
                    if (cnt_q == CWID'(FRWID - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        vld_d   = 1'b1;
                        upd_d   = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            frac_q  <= '0;
            int_q   <= '0;
            vld_q   <= 1'b0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            frac_q  <= frac_d;
            int_q   <= int_d;
            vld_q   <= vld_d;
            upd_q   <= upd_d;
            busy_q  <= busy_d;
        end
    end

    assign o_frac    = frac_q;
    assign o_log2    = {int_q, frac_q};
    assign o_val_vld = vld_q;
    assign o_val_upd = upd_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_ip_log2frac.sv
// tb_ip_log2frac: directed and chained checks for the fractional log2 stage.
module tb_ip_log2frac;

    localparam int unsigned IDWID = 16;
    localparam int unsigned ODWID = 4;
    localparam int unsigned FRWID = 8;

    logic                   clk;
    logic                   rst_n;
    logic                   i_cal_str;
    logic [IDWID-1:0]       i_val;
    logic [ODWID-1:0]       i_int;
    logic [FRWID-1:0]       o_frac;
    logic [ODWID+FRWID-1:0] o_log2;
    logic                   o_val_vld;
    logic                   o_val_upd;
    logic                   o_busy;

    int n_chk  = 0;
    int n_fail = 0;

    ip_log2frac #(.IDWID(IDWID), .ODWID(ODWID), .FRWID(FRWID), .MWID(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_cal_str (i_cal_str),
        .i_val     (i_val),
        .i_int     (i_int),
        .o_frac    (o_frac),
        .o_log2    (o_log2),
        .o_val_vld (o_val_vld),
        .o_val_upd (o_val_upd),
        .o_busy    (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a start for one cycle; called at a negedge, returns at the next.
    task automatic start(input logic [IDWID-1:0] v, input logic [ODWID-1:0] ii);
        i_cal_str = 1'b1;
        i_val     = v;
        i_int     = ii;
        @(negedge clk);
        i_cal_str = 1'b0;
    endtask

    // Walk the 8 iteration edges after a start and check result and timing.
    task automatic finish_check(input string tag, input int exp_int, input int exp_frac);
        int bad;
        bad = 0;
        for (int k = 1; k < FRWID; k++) begin
            @(negedge clk);
            if (o_val_upd !== 1'b0 || o_busy !== 1'b1 || o_val_vld !== 1'b0) bad++;
        end
        check({tag, "_mid"}, 32'(bad), 32'd0);
        @(negedge clk);
        check({tag, "_upd"},  32'(o_val_upd), 32'd1);
        check({tag, "_vld"},  32'(o_val_vld), 32'd1);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_frac"}, 32'(o_frac), 32'(exp_frac));
        check({tag, "_log2"}, 32'(o_log2), 32'((exp_int << FRWID) | exp_frac));
        @(negedge clk);
        check({tag, "_upd1t"}, 32'(o_val_upd), 32'd0);
        check({tag, "_hold"},  32'(o_val_vld), 32'd1);
    endtask

    function automatic int flog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) if (((v >> i) & 1) != 0) r = i;
        return r;
    endfunction

    initial begin
        int bad;
        int il;
        int ef;
        int diff;
        int v;
        real lf;

        rst_n     = 1'b0;
        i_cal_str = 1'b0;
        i_val     = '0;
        i_int     = '0;
        repeat (2) @(negedge clk);
        check("rst_log2", 32'(o_log2), 32'd0);
        check("rst_vld",  32'(o_val_vld), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_upd",  32'(o_val_upd), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // log2(1) = 0
        start(16'h0001, 4'd0);
        check("one_busy0", 32'(o_busy), 32'd1);
        finish_check("one", 0, 8'h00);

        // log2(3) = 1.58496 -> 0x95
        start(16'h0003, 4'd1);
        check("three_busy0", 32'(o_busy), 32'd1);
        check("three_vld0",  32'(o_val_vld), 32'd0);
        finish_check("three", 1, 8'h95);

        // Near-2 mantissa, then exact power of two; vld drops on the start.
        start(16'hFFFF, 4'd15);
        finish_check("ffff", 15, 8'hFF);
        start(16'h8000, 4'd15);
        check("p2_vlddrop", 32'(o_val_vld), 32'd0);
        finish_check("p2", 15, 8'h00);

        // Standalone log2(10) = 3.32193 -> 0x52
        start(16'h000A, 4'd3);
        finish_check("ten", 3, 8'h52);

        // Restart at iteration 4: first result discarded, no pulse for it.
        start(16'h000A, 4'd3);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_val_upd !== 1'b0) bad++;
        end
        check("rst4_pre", 32'(bad), 32'd0);
        start(16'h0003, 4'd1);
        check("rst4_busy", 32'(o_busy), 32'd1);
        finish_check("restart", 1, 8'h95);

        // Start coinciding with the final iteration edge: start wins.
        start(16'h0003, 4'd1);
        repeat (FRWID - 1) @(negedge clk);
        start(16'h8000, 4'd15);
        check("coin_upd",  32'(o_val_upd), 32'd0);
        check("coin_vld",  32'(o_val_vld), 32'd0);
        check("coin_busy", 32'(o_busy), 32'd1);
        finish_check("coin", 15, 8'h00);

        // Inconsistent integer part: mantissa underflows to zero.
        start(16'h0003, 4'd5);
        finish_check("incons", 5, 8'h00);

        // Zero operand.
        start(16'h0000, 4'd0);
        finish_check("zero", 0, 8'h00);

        // Asynchronous reset mid-iteration.
        start(16'h0003, 4'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_log2", 32'(o_log2), 32'd0);
        check("arst_flags", 32'({o_val_vld, o_val_upd, o_busy}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (o_val_upd !== 1'b0 || o_val_vld !== 1'b0 || o_busy !== 1'b0) bad++;
        end
        check("arst_quiet", 32'(bad), 32'd0);

        // Chained with a behavioural integer-log2 upstream stage.
        for (int n = 0; n < 20; n++) begin
            v  = int'($urandom_range(1, 65535));
            il = flog2(v);
            lf = ($ln(real'(v)) / $ln(2.0) - real'(il)) * 256.0;
            ef = int'($floor(lf));
            if (ef < 0) ef = 0;
            if (ef > 255) ef = 255;
            start(IDWID'(v), ODWID'(il));
            repeat (FRWID) @(negedge clk);
            check("chain_upd", 32'(o_val_upd), 32'd1);
            check("chain_int", 32'(o_log2[ODWID+FRWID-1:FRWID]), 32'(il));
            diff = ef - int'(o_frac);
            if (diff < -1 || diff > 1)
                check("chain_frac", 32'(o_frac), 32'(ef));
            else
                check("chain_frac", 32'(1), 32'd1);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
